// File: rtl/poly_crc_engine.sv
// poly_crc_engine: runtime-configurable bit-serial CRC engine.
//
// Each accepted data word is shifted MSB-first through the CRC state,
// BPC bits per clock, so one word takes DATA_W/BPC processing cycles plus
// the acceptance cycle. The polynomial is captured when a word is accepted.
// Reflection of the output and the final XOR are applied combinationally
// from the live config, so they may change at any time.
//
// Ports:
//   CLK, nRST      clock (rising edge), asynchronous active-low reset
//   cfg_poly       polynomial, x^CRC_W term implicit
//   cfg_seed       value loaded into the state by init
//   cfg_refin      reverse bits within each input byte
//   cfg_refout     bit-reverse the whole state before the final XOR
//   cfg_xorout     final XOR mask
//   init           load cfg_seed into the state (idle only)
//   in_valid       in_data holds a word
//   in_data        data word, most-significant byte processed first
//   in_ready       engine idle, can accept a word or init
//   done           one-cycle pulse, crc_out holds the updated result
//   crc_out        (refout ? rev(state) : state) ^ xorout
//   busy           !in_ready
//   dbg_state      current FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready
// are both high. The producer holds in_valid and in_data stable until that
// edge; in_ready is low for the whole of RUN, so nothing is accepted then.

module poly_crc_engine #(
    parameter int CRC_W  = 32,
    parameter int DATA_W = 32,
    parameter int BPC    = 1,
    localparam int CYCLES = DATA_W / BPC,
    localparam int CNT_W  = $clog2(CYCLES + 1)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [CRC_W-1:0]  cfg_poly,
    input  logic [CRC_W-1:0]  cfg_seed,
    input  logic              cfg_refin,
    input  logic              cfg_refout,
    input  logic [CRC_W-1:0]  cfg_xorout,
    input  logic              init,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              done,
    output logic [CRC_W-1:0]  crc_out,
    output logic              busy,
    output logic              dbg_state
);

    if (CRC_W < 8 || CRC_W > 64) begin : g_bad_crc_w
        $error("poly_crc_engine: CRC_W must be in 8..64");
    end
    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("poly_crc_engine: DATA_W must be a multiple of 8");
    end
    if (BPC < 1 || DATA_W % BPC != 0) begin : g_bad_bpc
        $error("poly_crc_engine: BPC must divide DATA_W");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    fsm_t              fsm_q, fsm_d;
    logic [CRC_W-1:0]  state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CRC_W-1:0]  poly_q, poly_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;

    logic [CRC_W-1:0]  step_state;
    logic [DATA_W-1:0] step_shreg;
    logic [CRC_W-1:0]  state_rev;

    // Reverse the bit order inside every byte; byte positions are unchanged,
    // so the most-significant byte is still consumed first.
    function automatic logic [DATA_W-1:0] byte_reflect(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W / 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                r[8*i + j] = d[8*i + 7 - j];
            end
        end
        return r;
    endfunction

    // BPC chained single-bit LFSR steps; returns {state, shreg}.
    function automatic logic [CRC_W+DATA_W-1:0] run_steps(
        input logic [CRC_W-1:0]  st,
        input logic [DATA_W-1:0] sh,
        input logic [CRC_W-1:0]  poly
    );
        logic [CRC_W-1:0]  s;
        logic [DATA_W-1:0] d;
        logic              fb;
        s = st;
        d = sh;
        for (int i = 0; i < BPC; i++) begin
            fb = d[DATA_W-1] ^ s[CRC_W-1];
            s  = (s << 1) ^ (fb ? poly : '0);
            d  = d << 1;
        end
        return {s, d};
    endfunction

    assign {step_state, step_shreg} = run_steps(state_q, shreg_q, poly_q);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            shreg_q <= '0;
            poly_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            shreg_q <= shreg_d;
            poly_q  <= poly_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        shreg_d = shreg_q;
        poly_d  = poly_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (fsm_q)
            IDLE: begin
                // init alone reseeds; with in_valid the word starts from the seed.
                if (init) begin
                    state_d = cfg_seed;
                end
                if (in_valid) begin
                    shreg_d = cfg_refin ? byte_reflect(in_data) : in_data;
                    poly_d  = cfg_poly;
                    cnt_d   = CNT_W'(CYCLES);
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                state_d = step_state;
                shreg_d = step_shreg;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    fsm_d  = IDLE;
                    done_d = 1'b1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        state_rev = '0;
        for (int i = 0; i < CRC_W; i++) begin
            state_rev[i] = state_q[CRC_W-1-i];
        end
    end

    assign crc_out   = (cfg_refout ? state_rev : state_q) ^ cfg_xorout;
    assign in_ready  = (fsm_q == IDLE);
    assign busy      = !in_ready;
    assign done      = done_q;
    assign dbg_state = (fsm_q == RUN);

endmodule

// File: tb/tb_poly_crc_engine.sv
// tb_poly_crc_engine: checks poly_crc_engine in four configurations
//   u_a: CRC_W=32, DATA_W=8,  BPC=1  (9 cycles per byte)
//   u_b: CRC_W=16, DATA_W=8,  BPC=8  (2 cycles per byte)
//   u_c: CRC_W=8,  DATA_W=8,  BPC=4  (3 cycles per byte)
//   u_d: CRC_W=32, DATA_W=32, BPC=1  (33 cycles per word)
// Known catalogue check values on "123456789", randomized messages against a
// byte-wise long-division model, and hand-written multi-cycle corner cases.

module tb_poly_crc_engine;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    logic [31:0] cfg_poly, cfg_seed, cfg_xorout;
    logic        cfg_refin, cfg_refout;
    logic [2:0]  vld, ini;
    logic [7:0]  din;
    logic [2:0]  rdy, dn, bsy, dbg;
    logic [31:0] crc_a;
    logic [15:0] crc_b;
    logic [7:0]  crc_c;

    logic        d_valid, d_init, d_ready, d_done, d_busy, d_dbg;
    logic [31:0] d_data, d_crc;

    int total = 0;
    int bad = 0;

    logic [31:0] exp_st[3];
    logic [31:0] exp_d;
    logic [31:0] exp_q[$];

    poly_crc_engine #(.CRC_W(32), .DATA_W(8), .BPC(1)) u_a (
        .CLK(CLK), .nRST(nRST),
        .cfg_poly(cfg_poly), .cfg_seed(cfg_seed), .cfg_refin(cfg_refin),
        .cfg_refout(cfg_refout), .cfg_xorout(cfg_xorout),
        .init(ini[0]), .in_valid(vld[0]), .in_data(din),
        .in_ready(rdy[0]), .done(dn[0]), .crc_out(crc_a), .busy(bsy[0]),
        .dbg_state(dbg[0])
    );

    poly_crc_engine #(.CRC_W(16), .DATA_W(8), .BPC(8)) u_b (
        .CLK(CLK), .nRST(nRST),
        .cfg_poly(cfg_poly[15:0]), .cfg_seed(cfg_seed[15:0]), .cfg_refin(cfg_refin),
        .cfg_refout(cfg_refout), .cfg_xorout(cfg_xorout[15:0]),
        .init(ini[1]), .in_valid(vld[1]), .in_data(din),
        .in_ready(rdy[1]), .done(dn[1]), .crc_out(crc_b), .busy(bsy[1]),
        .dbg_state(dbg[1])
    );

    poly_crc_engine #(.CRC_W(8), .DATA_W(8), .BPC(4)) u_c (
        .CLK(CLK), .nRST(nRST),
        .cfg_poly(cfg_poly[7:0]), .cfg_seed(cfg_seed[7:0]), .cfg_refin(cfg_refin),
        .cfg_refout(cfg_refout), .cfg_xorout(cfg_xorout[7:0]),
        .init(ini[2]), .in_valid(vld[2]), .in_data(din),
        .in_ready(rdy[2]), .done(dn[2]), .crc_out(crc_c), .busy(bsy[2]),
        .dbg_state(dbg[2])
    );

    poly_crc_engine #(.CRC_W(32), .DATA_W(32), .BPC(1)) u_d (
        .CLK(CLK), .nRST(nRST),
        .cfg_poly(cfg_poly), .cfg_seed(cfg_seed), .cfg_refin(cfg_refin),
        .cfg_refout(cfg_refout), .cfg_xorout(cfg_xorout),
        .init(d_init), .in_valid(d_valid), .in_data(d_data),
        .in_ready(d_ready), .done(d_done), .crc_out(d_crc), .busy(d_busy),
        .dbg_state(d_dbg)
    );

    // ---------------- helpers and reference model ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int wid(input int k);
        return (k == 0) ? 32 : (k == 1) ? 16 : 8;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 9 : (k == 1) ? 2 : 3;
    endfunction

    function automatic logic [31:0] mask(input int w);
        logic [63:0] m;
        m = (64'h1 << w) - 64'h1;
        return m[31:0];
    endfunction

    function automatic logic [31:0] crc_of(input int k);
        if (k == 0) return crc_a;
        if (k == 1) return {16'h0, crc_b};
        return {24'h0, crc_c};
    endfunction

    // Textbook byte-at-a-time polynomial division (MSB-first register).
    function automatic logic [31:0] m_byte(input int w, input logic [31:0] poly,
                                           input logic [31:0] st, input logic refin,
                                           input logic [7:0] b);
        logic [63:0] s;
        logic [7:0]  bb;
        bb = b;
        if (refin) for (int j = 0; j < 8; j++) bb[j] = b[7-j];
        s = {32'h0, st & mask(w)} ^ ({56'h0, bb} << (w - 8));
        for (int j = 0; j < 8; j++) begin
            if (s[w-1]) s = (s << 1) ^ {32'h0, poly & mask(w)};
            else        s = s << 1;
            s = s & {32'h0, mask(w)};
        end
        return s[31:0];
    endfunction

    function automatic logic [31:0] m_final(input int w, input logic [31:0] st,
                                            input logic refout, input logic [31:0] xo);
        logic [31:0] r;
        r = st & mask(w);
        if (refout) begin
            r = '0;
            for (int i = 0; i < w; i++) r[i] = st[w-1-i];
        end
        return (r ^ xo) & mask(w);
    endfunction

    // ---------------- drivers ----------------
    task automatic do_init(input int k);
        ini[k] = 1'b1;
        @(posedge CLK);
        #1 ini[k] = 1'b0;
        exp_st[k] = cfg_seed & mask(wid(k));
        @(negedge CLK);
        chk($sformatf("init_crc_%0d", k), crc_of(k),
            m_final(wid(k), exp_st[k], cfg_refout, cfg_xorout));
    endtask

    // Send one byte, wait for done, check latency and result.
    task automatic xfer(input int k, input logic [7:0] b, input logic with_init);
        int n;
        logic [31:0] e;
        if (with_init) exp_st[k] = cfg_seed & mask(wid(k));
        exp_st[k] = m_byte(wid(k), cfg_poly, exp_st[k], cfg_refin, b);
        exp_q.push_back(m_final(wid(k), exp_st[k], cfg_refout, cfg_xorout));
        din = b;
        vld[k] = 1'b1;
        ini[k] = with_init;
        n = 0;
        while (!rdy[k] && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!rdy[k]) chk($sformatf("ready_timeout_%0d", k), 32'(rdy[k]), 32'd1);
        @(posedge CLK);
        #1;
        vld[k] = 1'b0;
        ini[k] = 1'b0;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!dn[k] && n < 100);
        chk($sformatf("latency_%0d", k), 32'(n), 32'(lat_of(k)));
        e = exp_q.pop_front();
        chk($sformatf("crc_%0d", k), crc_of(k), e);
    endtask

    // 32-bit word on u_d. 'abuse' holds in_valid through RUN and pulses init mid-run.
    task automatic xfer_d(input logic [31:0] wd, input logic with_init, input logic abuse);
        int n, rdy_err;
        logic [31:0] e;
        if (with_init) exp_d = cfg_seed;
        for (int i = 3; i >= 0; i--) exp_d = m_byte(32, cfg_poly, exp_d, cfg_refin, wd[8*i +: 8]);
        e = m_final(32, exp_d, cfg_refout, cfg_xorout);
        d_data = wd;
        d_valid = 1'b1;
        d_init = with_init;
        n = 0;
        while (!d_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        @(posedge CLK);
        #1;
        d_init = 1'b0;
        if (!abuse) d_valid = 1'b0;
        n = 0;
        rdy_err = 0;
        do begin
            @(negedge CLK);
            n++;
            if (n < 33 && d_ready) rdy_err++;
            if (abuse && n == 10) d_init = 1'b1;
            if (abuse && n == 12) d_init = 1'b0;
        end while (!d_done && n < 100);
        d_valid = 1'b0;
        chk("d_latency", 32'(n), 32'd33);
        chk("d_ready_low_in_run", 32'(rdy_err), 32'd0);
        chk("d_crc", d_crc, e);
        @(negedge CLK);
        chk("d_done_one_cycle", 32'(d_done), 32'd0);
        chk("d_no_double_accept", 32'(d_ready), 32'd1);
    endtask

    task automatic set_cfg(input logic [31:0] p, input logic [31:0] s, input logic ri,
                           input logic ro, input logic [31:0] x);
        cfg_poly = p;
        cfg_seed = s;
        cfg_refin = ri;
        cfg_refout = ro;
        cfg_xorout = x;
    endtask

    typedef struct {
        int          k;
        logic [31:0] poly;
        logic [31:0] seed;
        logic        refin;
        logic        refout;
        logic [31:0] xorout;
        logic [31:0] check;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int n, len;
        vld = '0;
        ini = '0;
        din = '0;
        d_valid = 1'b0;
        d_init = 1'b0;
        d_data = '0;
        set_cfg(32'h04C11DB7, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h12345678);
        for (int k = 0; k < 3; k++) exp_st[k] = '0;
        exp_d = '0;

        vecs[0] = '{0, 32'h04C11DB7, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hCBF43926};
        vecs[1] = '{0, 32'h04C11DB7, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, 32'h0376E6E7};
        vecs[2] = '{1, 32'h00001021, 32'h0000FFFF, 1'b0, 1'b0, 32'h00000000, 32'h000029B1};
        vecs[3] = '{1, 32'h00001021, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 32'h000031C3};
        vecs[4] = '{1, 32'h00008005, 32'h00000000, 1'b1, 1'b1, 32'h00000000, 32'h0000BB3D};
        vecs[5] = '{2, 32'h00000007, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 32'h000000F4};
        vecs[6] = '{2, 32'h00000031, 32'h00000000, 1'b1, 1'b1, 32'h00000000, 32'h000000A1};

        // Reset state: state=0, so crc_out is just the xorout mask.
        @(negedge CLK);
        chk("rst_ready", 32'(rdy), 32'h7);
        chk("rst_done", 32'(dn), 32'h0);
        chk("rst_busy", 32'(bsy), 32'h0);
        chk("rst_dbg", 32'(dbg), 32'h0);
        chk("rst_crc_a", crc_a, 32'h12345678);
        chk("rst_crc_b", 32'(crc_b), 32'h5678);
        chk("rst_crc_c", 32'(crc_c), 32'h78);
        chk("rst_crc_d", d_crc, 32'h12345678);
        chk("rst_ready_d", 32'(d_ready), 32'd1);
        #2 nRST = 1'b1;

        // Catalogue vectors on "123456789", one byte per handshake, back-to-back.
        for (int v = 0; v < 7; v++) begin
            set_cfg(vecs[v].poly, vecs[v].seed, vecs[v].refin, vecs[v].refout, vecs[v].xorout);
            do_init(vecs[v].k);
            for (int i = 0; i < 9; i++) xfer(vecs[v].k, 8'(8'h31 + i), 1'b0);
            chk($sformatf("vec%0d_check", v), crc_of(vecs[v].k), vecs[v].check);
            @(negedge CLK);
            chk($sformatf("vec%0d_done_pulse", v), 32'(dn[vecs[v].k]), 32'd0);
        end

        // Randomized configs and messages.
        for (int r = 0; r < 9; r++) begin
            int k;
            k = r % 3;
            set_cfg($urandom() | 32'h1, $urandom(), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom());
            do_init(k);
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) xfer(k, 8'($urandom_range(0, 255)), 1'b0);
        end

        // init and in_valid together: word processed from the seed.
        set_cfg(32'h04C11DB7, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFF);
        do_init(0);
        xfer(0, 8'hA7, 1'b0);
        xfer(0, 8'h31, 1'b1);
        cfg_refout = 1'b0;
        #1 chk("live_refout", crc_a, m_final(32, exp_st[0], 1'b0, 32'hFFFFFFFF));
        cfg_refout = 1'b1;

        // 32-bit words: latency, held in_valid, init during RUN.
        @(negedge CLK);
        xfer_d(32'h31323334, 1'b1, 1'b0);
        xfer_d(32'h35363738, 1'b0, 1'b1);
        xfer_d(32'h39000000, 1'b0, 1'b0);

        // Asynchronous reset in the middle of RUN.
        do_init(0);
        din = 8'h55;
        vld[0] = 1'b1;
        @(posedge CLK);
        #1 vld[0] = 1'b0;
        repeat (5) @(negedge CLK);
        chk("mid_busy", 32'(bsy[0]), 32'd1);
        chk("mid_dbg", 32'(dbg[0]), 32'd1);
        nRST = 1'b0;
        #1;
        chk("arst_ready", 32'(rdy[0]), 32'd1);
        chk("arst_done", 32'(dn[0]), 32'd0);
        chk("arst_crc", crc_a, m_final(32, 32'h0, cfg_refout, cfg_xorout));
        chk("arst_dbg", 32'(dbg[0]), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        for (int k = 0; k < 3; k++) exp_st[k] = '0;
        exp_d = '0;
        n = 0;
        repeat (12) begin
            @(negedge CLK);
            if (dn[0]) n++;
        end
        chk("arst_no_done", 32'(n), 32'd0);
        xfer(0, 8'h41, 1'b0);
        xfer(0, 8'h42, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/poly_crc_engine.md
# poly_crc_engine

Parametrised, runtime-configurable CRC engine for the APB CRC peripheral, and the next generation of the 32-bit serial polymorphic CRC unit. CRC width, input word width and bits processed per clock are compile-time parameters. Polynomial, seed, input/output reflection and final XOR are runtime inputs. Input uses a valid/ready handshake, and a one-cycle `done` pulse marks each updated result; the APB register wrapper drives the config and data ports.

## Interface
- `CRC_W`, default 32: CRC register width; legal range 8..64.
- `DATA_W`, default 32: input word width; must be a multiple of 8.
- `BPC`, default 1: data bits consumed per clock; must divide `DATA_W`.
- `CYCLES`, derived as `DATA_W/BPC`: processing cycles per word.
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `cfg_poly` in `CRC_W`: polynomial, x^CRC_W term implicit.
- `cfg_seed` in `CRC_W`: initial CRC value.
- `cfg_refin` in 1: reflect input; each byte is processed LSB-first.
- `cfg_refout` in 1: bit-reverse the whole CRC state before XOR-out.
- `cfg_xorout` in `CRC_W`: final XOR mask.
- `init` in 1: load `cfg_seed` into the state (pulse).
- `in_valid` in 1: `in_data` is valid.
- `in_data` in `DATA_W`: data word, most-significant byte processed first.
- `in_ready` out 1: engine idle and able to accept a word or `init`.
- `done` out 1: one-cycle pulse; `crc_out` is updated.
- `crc_out` out `CRC_W`: `(cfg_refout ? rev(state) : state) ^ cfg_xorout`. Combinational from the registered state and the live cfg inputs.
- `busy` out 1: equals `!in_ready`.

## Operation
- FSM states: IDLE and RUN.
- Registers:
  - `state[CRC_W]`
  - `shreg[DATA_W]`
  - `poly_q`
  - `cnt` (`$clog2(CYCLES+1)` bits)
  - `done`
- Reset values:
  - `state` = 0, `shreg` = 0, `poly_q` = 0, `cnt` = 0.
  - FSM in IDLE, so `in_ready`=1, `busy`=0, `done`=0.
  - `crc_out` = 0 reflected per live cfg, then XORed with `cfg_xorout`.
- IDLE, `init`=1 and `in_valid`=0: `state` <- `cfg_seed`; stay in IDLE; no `done` pulse.
- IDLE, `in_valid`=1 (acceptance):
  - `shreg` <- `in_data`. When `cfg_refin`=1, bits are reversed within each byte; byte order is kept.
  - `poly_q` <- `cfg_poly`.
  - `cnt` <- `CYCLES`; go to RUN.
  - If `init`=1 in the same cycle, `state` <- `cfg_seed` at this edge, and the word is processed from the seed.
- RUN, each edge: apply `BPC` single-bit steps, in order, to `state`.
  - Bit step: `b = shreg[DATA_W-1]`, `fb = b ^ state[CRC_W-1]`, `state = (state<<1) ^ (fb ? poly_q : 0)`, `shreg = shreg<<1`.
  - `cnt` <- `cnt-1`.
  - When `cnt` goes from 1 to 0: go to IDLE and set `done`<=1 for exactly one cycle.
- In RUN, `init`, `in_valid` and changes to `cfg_poly` or `cfg_refin` are ignored. The upstream must hold `in_valid`/`in_data` until `in_ready`.
- `cfg_refout` and `cfg_xorout` are not latched; a change is reflected in `crc_out` immediately.
- The state is never cleared between words; multi-word messages chain naturally until the next `init`.
- All shift and XOR arithmetic is modulo 2^`CRC_W`, with no carries. `rev()` swaps bit i with bit `CRC_W-1-i`.

## Timing
- Word accepted at edge E0; state updates at edges E1..E`CYCLES`.
- `done`=1 and the final `crc_out` appear in the cycle after E`CYCLES`.
- `in_ready` rises in the same cycle as `done`, so back-to-back words are accepted one per `CYCLES+1` cycles.
- Example latencies:
  - `DATA_W`=32, `BPC`=1: 33 cycles per word.
  - `DATA_W`=8, `BPC`=8: 2 cycles per word.
- `init` with no data takes effect at the next edge and is visible on `crc_out` in the following cycle.
- `nRST` asserted in RUN: the word is abandoned and all registers return to reset values asynchronously. No `done` pulse is produced, and `in_ready`=1 immediately.
- `crc_out` is not glitch-protected against changes to `cfg_refout` or `cfg_xorout`. Consumers sample it on `done`, or while idle with stable config.

## Test plan
- CRC-32, `CRC_W`=32, `DATA_W`=8, `BPC`=1:
  - Config: poly `04C11DB7`, seed `FFFFFFFF`, refin=1, refout=1, xorout `FFFFFFFF`.
  - Stimulus: `init`, then ASCII "123456789" one byte per handshake.
  - Required: `crc_out`=`CBF43926` at the last `done`; 9 `done` pulses, 9 cycles apart.
- Same bytes with refin=0, refout=0, xorout=0 (CRC-32/MPEG-2) -> `0376E6E7`.
- `CRC_W`=16, `DATA_W`=8, `BPC`=8:
  - Config: poly `1021`, seed `FFFF`, xorout 0, refin=0, refout=0 (CCITT-FALSE).
  - Stimulus: "123456789".
  - Required: `29B1`; `done` arrives 2 cycles after each acceptance.
- `CRC_W`=8, poly `07`, seed 0, refin=0, refout=0, xorout 0, on "123456789" -> `F4`.
- `DATA_W`=32, `BPC`=1, 4-byte words `31323334`, `35363738`, `39`-padded:
  - Check: 33-cycle latency per word.
  - Check: `in_valid` held during RUN is not double-accepted.
  - Check: `init` during RUN is ignored.
- Corner cases:
  - `init`+`in_valid` in the same cycle -> result equals seed-then-word.
  - `nRST` pulse at cycle 5 of RUN -> `crc_out` returns to its reset value, no `done` pulse, and the next word is accepted normally.
